cok_kanalli_veriyolu: RTL and testbench

Parametrised N-channel bus controller between the L1 caches (and any further line-sized requesters) and the two memory targets: the line-wide main-memory port and the word-wide Wishbone MMIO bridge. Requests are arbitrated round-robin and the grant is locked from acceptance to completion. Requests are decoded by address. Every transaction is bounded by a timeout that returns an error. It supersedes the fixed two-port, fixed-priority controller.

---
 rtl/cok_kanalli_veriyolu_pkg.sv | 23 ++
 rtl/cok_kanalli_veriyolu_hakem.sv | 36 +++
 rtl/cok_kanalli_veriyolu.sv | 169 ++++++++++++++++
 tb/tb_cok_kanalli_veriyolu.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cok_kanalli_veriyolu_pkg.sv
// Shared definitions for the N-channel bus controller: FSM states, default
// configuration values and a width helper.
package cok_kanalli_veriyolu_pkg;

  typedef enum logic [1:0] {
    BOSTA     = 2'd0,
    RAM_BEKLE = 2'd1,
    WB_BEKLE  = 2'd2,
    DONUS     = 2'd3
  } durum_e;

  localparam int unsigned VARSAYILAN_ADRES_GENISLIGI     = 32;
  localparam int unsigned VARSAYILAN_SOZCUK_GENISLIGI    = 32;
  localparam int unsigned VARSAYILAN_SATIR_SOZCUK_SAYISI = 4;
  localparam logic [31:0] VARSAYILAN_BASLANGIC_ADRESI    = 32'h8000_0000;
  localparam int unsigned VARSAYILAN_ZAMAN_ASIMI         = 1023;

  // Never returns 0 so that index/counter vectors stay legal for tiny values.
  function automatic int unsigned bit_sayisi(input int unsigned deger);
    return (deger <= 1) ? 1 : $clog2(deger);
  endfunction

endpackage

// File: rtl/cok_kanalli_veriyolu_hakem.sv
// Round-robin arbiter: searches upward from the channel after the pointer and
// returns the first requester as a one-hot grant plus its index.
module dongusel_hakem
  import cok_kanalli_veriyolu_pkg::*;
#(
  parameter int unsigned KANAL_SAYISI = 2,
  localparam int unsigned IW = bit_sayisi(KANAL_SAYISI)
) (
  input  logic [KANAL_SAYISI-1:0] istek_i,
  input  logic [IW-1:0]           isaretci_i,
  output logic [KANAL_SAYISI-1:0] hibe_o,
  output logic [IW-1:0]           indeks_o
);

  logic          bulundu;
  int            aday_int;
  logic [IW-1:0] aday;

  always_comb begin
    hibe_o   = '0;
    indeks_o = '0;
    bulundu  = 1'b0;
    aday_int = 0;
    aday     = '0;
    for (int i = 1; i <= int'(KANAL_SAYISI); i++) begin
      aday_int = (int'(isaretci_i) + i) % int'(KANAL_SAYISI);
      aday     = IW'(aday_int);
      if (!bulundu && istek_i[aday]) begin
        bulundu      = 1'b1;
        indeks_o     = aday;
        hibe_o[aday] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cok_kanalli_veriyolu.sv
// N-channel line bus controller: round-robin grant locked until completion,
// address decode to main memory or the Wishbone MMIO bridge, per-transaction timeout.
module cok_kanalli_veriyolu
  import cok_kanalli_veriyolu_pkg::*;
#(
  parameter int unsigned ADRES_GENISLIGI     = VARSAYILAN_ADRES_GENISLIGI,
  parameter int unsigned SOZCUK_GENISLIGI    = VARSAYILAN_SOZCUK_GENISLIGI,
  parameter int unsigned SATIR_SOZCUK_SAYISI = VARSAYILAN_SATIR_SOZCUK_SAYISI,
  parameter int unsigned KANAL_SAYISI        = 2,
  parameter logic [ADRES_GENISLIGI-1:0] BASLANGIC_ADRESI =
    ADRES_GENISLIGI'(VARSAYILAN_BASLANGIC_ADRESI),
  parameter int unsigned ZAMAN_ASIMI         = VARSAYILAN_ZAMAN_ASIMI,
  localparam int unsigned SATIR = SATIR_SOZCUK_SAYISI * SOZCUK_GENISLIGI
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [KANAL_SAYISI*ADRES_GENISLIGI-1:0] k_adres_i,
  input  logic [KANAL_SAYISI*SATIR-1:0]           k_veri_i,
  input  logic [KANAL_SAYISI-1:0]                 k_istek_gecerli_i,
  input  logic [KANAL_SAYISI-1:0]                 k_yaz_i,
  output logic [SATIR-1:0]                        k_veri_o,
  output logic [KANAL_SAYISI-1:0]                 k_veri_hazir_o,
  output logic [KANAL_SAYISI-1:0]                 k_hata_o,
  output logic [ADRES_GENISLIGI-1:0]              ram_adres_o,
  output logic                                    ram_istek_gecerli_o,
  output logic [SATIR-1:0]                        ram_yazilacak_veri_o,
  output logic                                    ram_yaz_o,
  input  logic [SATIR-1:0]                        ram_okunan_veri_i,
  input  logic                                    ram_hazir_i,
  output logic [ADRES_GENISLIGI-1:0]              wb_adr_o,
  output logic [SOZCUK_GENISLIGI-1:0]             wb_veri_o,
  output logic                                    wb_yaz_o,
  output logic                                    wb_istek_o,
  input  logic [SOZCUK_GENISLIGI-1:0]             wb_veri_i,
  input  logic                                    wb_hazir_i
);

  localparam int unsigned IW = bit_sayisi(KANAL_SAYISI);
  localparam int unsigned ZW = bit_sayisi(ZAMAN_ASIMI + 1);

  durum_e                       durum_q, durum_d;
  logic [IW-1:0]                son_q, son_d;
  logic [IW-1:0]                secili_q, secili_d;
  logic [ADRES_GENISLIGI-1:0]   adres_q, adres_d;
  logic [SATIR-1:0]             satir_q, satir_d;
  logic                         yaz_q, yaz_d;
  logic [ZW-1:0]                sayac_q, sayac_d;
  logic                         hata_q, hata_d;
  logic [SATIR-1:0]             veri_q, veri_d;

  logic [KANAL_SAYISI-1:0]      hakem_hibe;
  logic [IW-1:0]                hakem_indeks;
  logic [ADRES_GENISLIGI-1:0]   secili_adres;
  logic                         sure_doldu;

  dongusel_hakem #(
    .KANAL_SAYISI(KANAL_SAYISI)
  ) u_hakem (
    .istek_i   (k_istek_gecerli_i),
    .isaretci_i(son_q),
    .hibe_o    (hakem_hibe),
    .indeks_o  (hakem_indeks)
  );

  assign secili_adres = k_adres_i[hakem_indeks*ADRES_GENISLIGI +: ADRES_GENISLIGI];
  assign sure_doldu   = (sayac_q == ZW'(ZAMAN_ASIMI - 1));

  always_comb begin
    durum_d  = durum_q;
    son_d    = son_q;
    secili_d = secili_q;
    adres_d  = adres_q;
    satir_d  = satir_q;
    yaz_d    = yaz_q;
    sayac_d  = sayac_q;
    hata_d   = hata_q;
    veri_d   = veri_q;
    unique case (durum_q)
      BOSTA: begin
        if (|hakem_hibe) begin
          secili_d = hakem_indeks;
          adres_d  = secili_adres;
          satir_d  = k_veri_i[hakem_indeks*SATIR +: SATIR];
          yaz_d    = k_yaz_i[hakem_indeks];
          sayac_d  = '0;
          hata_d   = 1'b0;
          veri_d   = '0;
          durum_d  = (secili_adres >= BASLANGIC_ADRESI) ? RAM_BEKLE : WB_BEKLE;
        end
      end
      // Completion is tested before the timeout so a same-cycle tie succeeds.
      RAM_BEKLE: begin
        if (ram_hazir_i) begin
          if (!yaz_q) veri_d = ram_okunan_veri_i;
          durum_d = DONUS;
        end else if (sure_doldu) begin
          hata_d  = 1'b1;
          veri_d  = '0;
          durum_d = DONUS;
        end else begin
          sayac_d = sayac_q + 1'b1;
        end
      end
      WB_BEKLE: begin
        if (wb_hazir_i) begin
          if (!yaz_q) veri_d = SATIR'(wb_veri_i);
          durum_d = DONUS;
        end else if (sure_doldu) begin
          hata_d  = 1'b1;
          veri_d  = '0;
          durum_d = DONUS;
        end else begin
          sayac_d = sayac_q + 1'b1;
        end
      end
      DONUS: begin
        son_d   = secili_q;
        durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q  <= BOSTA;
      son_q    <= IW'(KANAL_SAYISI - 1);
      secili_q <= '0;
      adres_q  <= '0;
      satir_q  <= '0;
      yaz_q    <= 1'b0;
      sayac_q  <= '0;
      hata_q   <= 1'b0;
      veri_q   <= '0;
    end else begin
      durum_q  <= durum_d;
      son_q    <= son_d;
      secili_q <= secili_d;
      adres_q  <= adres_d;
      satir_q  <= satir_d;
      yaz_q    <= yaz_d;
      sayac_q  <= sayac_d;
      hata_q   <= hata_d;
      veri_q   <= veri_d;
    end
  end

  // Every output is decoded from registered state; nothing passes straight through.
  logic ram_aktif, wb_aktif, donus;
  logic [KANAL_SAYISI-1:0] secili_onehot;

  assign ram_aktif     = (durum_q == RAM_BEKLE);
  assign wb_aktif      = (durum_q == WB_BEKLE);
  assign donus         = (durum_q == DONUS);
  assign secili_onehot = KANAL_SAYISI'(1) << secili_q;

  assign k_veri_hazir_o       = donus ? secili_onehot : '0;
  assign k_hata_o             = (donus && hata_q) ? secili_onehot : '0;
  assign k_veri_o             = donus ? veri_q : '0;
  assign ram_istek_gecerli_o  = ram_aktif;
  assign ram_adres_o          = ram_aktif ? adres_q : '0;
  assign ram_yazilacak_veri_o = ram_aktif ? satir_q : '0;
  assign ram_yaz_o            = ram_aktif & yaz_q;
  assign wb_istek_o           = wb_aktif;
  assign wb_adr_o             = wb_aktif ? adres_q : '0;
  assign wb_veri_o            = wb_aktif ? satir_q[SOZCUK_GENISLIGI-1:0] : '0;
  assign wb_yaz_o             = wb_aktif & yaz_q;

endmodule

// File: tb/tb_cok_kanalli_veriyolu.sv
// Directed and randomized bench for the bus controller; requesters and targets
// are modelled as pending-request tables and scripted response latencies.
module tb_cok_kanalli_veriyolu;

  localparam int N = 3;
  localparam int AW = 32;
  localparam int WW = 32;
  localparam int LW = 4;
  localparam int SATIR = WW * LW;
  localparam int Z = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic                 clk;
  logic                 rst_i;
  logic [N*AW-1:0]      k_adres_i;
  logic [N*SATIR-1:0]   k_veri_i;
  logic [N-1:0]         k_istek_gecerli_i;
  logic [N-1:0]         k_yaz_i;
  logic [SATIR-1:0]     k_veri_o;
  logic [N-1:0]         k_veri_hazir_o;
  logic [N-1:0]         k_hata_o;
  logic [AW-1:0]        ram_adres_o;
  logic                 ram_istek_gecerli_o;
  logic [SATIR-1:0]     ram_yazilacak_veri_o;
  logic                 ram_yaz_o;
  logic [SATIR-1:0]     ram_okunan_veri_i;
  logic                 ram_hazir_i;
  logic [AW-1:0]        wb_adr_o;
  logic [WW-1:0]        wb_veri_o;
  logic                 wb_yaz_o;
  logic                 wb_istek_o;
  logic [WW-1:0]        wb_veri_i;
  logic                 wb_hazir_i;

  int vectors;
  int miscompares;

  bit               pend[N];
  logic [AW-1:0]    adr[N];
  logic [SATIR-1:0] line[N];
  bit               wr[N];
  int               last;

  cok_kanalli_veriyolu #(
    .ADRES_GENISLIGI    (AW),
    .SOZCUK_GENISLIGI   (WW),
    .SATIR_SOZCUK_SAYISI(LW),
    .KANAL_SAYISI       (N),
    .BASLANGIC_ADRESI   (BASE),
    .ZAMAN_ASIMI        (Z)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .k_adres_i           (k_adres_i),
    .k_veri_i            (k_veri_i),
    .k_istek_gecerli_i   (k_istek_gecerli_i),
    .k_yaz_i             (k_yaz_i),
    .k_veri_o            (k_veri_o),
    .k_veri_hazir_o      (k_veri_hazir_o),
    .k_hata_o            (k_hata_o),
    .ram_adres_o         (ram_adres_o),
    .ram_istek_gecerli_o (ram_istek_gecerli_o),
    .ram_yazilacak_veri_o(ram_yazilacak_veri_o),
    .ram_yaz_o           (ram_yaz_o),
    .ram_okunan_veri_i   (ram_okunan_veri_i),
    .ram_hazir_i         (ram_hazir_i),
    .wb_adr_o            (wb_adr_o),
    .wb_veri_o           (wb_veri_o),
    .wb_yaz_o            (wb_yaz_o),
    .wb_istek_o          (wb_istek_o),
    .wb_veri_i           (wb_veri_i),
    .wb_hazir_i          (wb_hazir_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [SATIR-1:0] obs, input logic [SATIR-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SATIR-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic cikis_var();
    return |{k_veri_o, k_veri_hazir_o, k_hata_o, ram_adres_o, ram_istek_gecerli_o,
             ram_yazilacak_veri_o, ram_yaz_o, wb_adr_o, wb_veri_o, wb_yaz_o, wb_istek_o};
  endfunction

  task automatic surucu();
    for (int c = 0; c < N; c++) begin
      k_istek_gecerli_i[c]          = pend[c];
      k_yaz_i[c]                    = wr[c];
      k_adres_i[c*AW +: AW]         = adr[c];
      k_veri_i[c*SATIR +: SATIR]    = line[c];
    end
  endtask

  task automatic istek_ver(input int c, input logic [AW-1:0] a, input bit w, input logic [SATIR-1:0] l);
    pend[c] = 1'b1;
    adr[c]  = a;
    wr[c]   = w;
    line[c] = l;
  endtask

  // One whole transaction from BOSTA; the target answers in wait cycle L
  // (0-based), so L >= Z means it never answers in time.
  task automatic islem(input int L, input bit drop, input logic [SATIR-1:0] resp, output int g_obs);
    int g;
    int n;
    bit to_ram;
    bit timeout;
    logic [SATIR-1:0] exp_data;
    g = -1;
    g_obs = -1;
    for (int i = 1; i <= N; i++)
      if (g < 0 && pend[(last + i) % N]) g = (last + i) % N;
    if (g < 0) return;
    to_ram   = (adr[g] >= BASE);
    timeout  = (L >= Z);
    exp_data = timeout ? '0 : (to_ram ? resp : {{(SATIR-WW){1'b0}}, resp[WW-1:0]});
    surucu();
    adim();
    chk("ram_istek", ram_istek_gecerli_o, to_ram);
    chk("wb_istek", wb_istek_o, !to_ram);
    if (to_ram) begin
      chk("ram_adres", ram_adres_o, adr[g]);
      chk("ram_yaz", ram_yaz_o, wr[g]);
      chk("ram_veri", ram_yazilacak_veri_o, line[g]);
    end else begin
      chk("wb_adr", wb_adr_o, adr[g]);
      chk("wb_yaz", wb_yaz_o, wr[g]);
      chk("wb_veri", wb_veri_o, line[g][WW-1:0]);
    end
    if (drop) k_istek_gecerli_i[g] = 1'b0;
    n = 0;
    for (int i = 0; i < Z + 4; i++) begin
      if (!(to_ram ? ram_istek_gecerli_o : wb_istek_o)) break;
      n++;
      ram_okunan_veri_i = rand_line();
      wb_veri_i = $urandom();
      if (i == L) begin
        if (to_ram) begin
          ram_hazir_i = 1'b1;
          ram_okunan_veri_i = resp;
        end else begin
          wb_hazir_i = 1'b1;
          wb_veri_i = resp[WW-1:0];
        end
      end
      adim();
      ram_hazir_i = 1'b0;
      wb_hazir_i  = 1'b0;
    end
    chk("istek_suresi", n, timeout ? Z : L + 1);
    chk("hazir", k_veri_hazir_o, N'(1) << g);
    chk("hata", k_hata_o, timeout ? (N'(1) << g) : N'(0));
    if (timeout || !wr[g]) chk("veri", k_veri_o, exp_data);
    for (int c = 0; c < N; c++) if (k_veri_hazir_o[c]) g_obs = c;
    pend[g] = 1'b0;
    surucu();
    last = g;
    adim();
    chk("hazir_tek_cevrim", k_veri_hazir_o, '0);
  endtask

  task automatic rastgele_istek(input int c);
    logic [AW-1:0] a;
    case ($urandom_range(0, 3))
      0: a = BASE + ($urandom_range(0, 15) << 2);
      1: a = BASE - 4 - ($urandom_range(0, 15) << 2);
      2: a = $urandom();
      default: a = {4'h2, 28'($urandom())};
    endcase
    istek_ver(c, a, bit'($urandom_range(0, 1)), rand_line());
  endtask

  initial begin
    int g;
    int say;
    vectors = 0;
    miscompares = 0;
    rst_i = 1'b1;
    k_adres_i = '0;
    k_veri_i = '0;
    k_istek_gecerli_i = '0;
    k_yaz_i = '0;
    ram_okunan_veri_i = '0;
    ram_hazir_i = 1'b0;
    wb_veri_i = '0;
    wb_hazir_i = 1'b0;
    for (int c = 0; c < N; c++) begin
      pend[c] = 1'b0;
      adr[c] = '0;
      line[c] = '0;
      wr[c] = 1'b0;
    end
    last = N - 1;
    repeat (3) adim();
    chk("reset_cikis", cikis_var(), 1'b0);
    rst_i = 1'b0;
    adim();
    chk("bosta_cikis", cikis_var(), 1'b0);

    // Completions on idle targets must be ignored.
    ram_hazir_i = 1'b1;
    wb_hazir_i = 1'b1;
    ram_okunan_veri_i = rand_line();
    wb_veri_i = 32'hDEAD_BEEF;
    adim();
    ram_hazir_i = 1'b0;
    wb_hazir_i = 1'b0;
    chk("bosta_tamamlama", cikis_var(), 1'b0);
    adim();
    chk("bosta_tamamlama2", cikis_var(), 1'b0);

    // Single RAM read.
    istek_ver(0, 32'h8000_0040, 1'b0, rand_line());
    islem(2, 1'b0, {4{32'hA5A5_A5A5}}, g);
    chk("ilk_hibe_k0", g, 0);

    // MMIO write from channel 1.
    istek_ver(1, 32'h2000_000C, 1'b1, {96'h1234_5678_9ABC_DEF0_1357_9BDF, 32'h0000_0041});
    islem(1, 1'b0, rand_line(), g);
    chk("mmio_hibe_k1", g, 1);

    // Contention fairness between ch0 and ch1.
    istek_ver(0, 32'h8000_0100, 1'b0, rand_line());
    istek_ver(1, 32'h8000_0200, 1'b0, rand_line());
    for (int k = 0; k < 4; k++) begin
      islem($urandom_range(0, 2), 1'b0, rand_line(), g);
      chk("adil_sira", g, k % 2);
      if (k < 2 && g >= 0) istek_ver(g, 32'h8000_0300 + (k << 4), 1'b0, rand_line());
    end

    // Timeout on RAM read.
    istek_ver(0, 32'h8000_1000, 1'b0, rand_line());
    islem(100, 1'b0, rand_line(), g);
    chk("zaman_asimi_k0", g, 0);

    // Decode boundary and completion/timeout tie.
    istek_ver(0, 32'h7FFF_FFFC, 1'b0, rand_line());
    islem(0, 1'b0, rand_line(), g);
    istek_ver(0, 32'h8000_0000, 1'b0, rand_line());
    islem(3, 1'b0, rand_line(), g);
    istek_ver(2, 32'h8000_0080, 1'b0, rand_line());
    islem(Z - 1, 1'b0, rand_line(), g);
    istek_ver(1, 32'h0000_1000, 1'b0, rand_line());
    islem(Z - 1, 1'b0, rand_line(), g);

    // Requester withdraws mid-transaction; completion still reported.
    istek_ver(1, 32'h8000_4000, 1'b1, rand_line());
    islem(2, 1'b1, rand_line(), g);
    chk("geri_cekme_k1", g, 1);

    // Reset during a RAM read.
    istek_ver(1, 32'h8000_2000, 1'b0, rand_line());
    surucu();
    adim();
    chk("rst_oncesi_istek", ram_istek_gecerli_o, 1'b1);
    adim();
    rst_i = 1'b1;
    adim();
    chk("rst_orta_cikis", cikis_var(), 1'b0);
    pend[1] = 1'b0;
    surucu();
    adim();
    chk("rst_orta_hazir_yok", cikis_var(), 1'b0);
    rst_i = 1'b0;
    last = N - 1;
    adim();
    chk("rst_sonrasi_bosta", cikis_var(), 1'b0);
    istek_ver(0, 32'h8000_0500, 1'b0, rand_line());
    istek_ver(1, 32'h8000_0600, 1'b0, rand_line());
    islem(1, 1'b0, rand_line(), g);
    chk("rst_sonrasi_k0", g, 0);
    islem(0, 1'b0, rand_line(), g);
    chk("rst_sonrasi_k1", g, 1);

    // Randomized traffic with persistent pending requests.
    for (int t = 0; t < 60; t++) begin
      for (int c = 0; c < N; c++)
        if (!pend[c] && $urandom_range(0, 1) == 1) rastgele_istek(c);
      say = 0;
      for (int c = 0; c < N; c++) if (pend[c]) say++;
      if (say == 0) rastgele_istek($urandom_range(0, N - 1));
      islem($urandom_range(0, 9), ($urandom_range(0, 3) == 0), rand_line(), g);
    end
    for (int k = 0; k < N; k++) begin
      say = 0;
      for (int c = 0; c < N; c++) if (pend[c]) say++;
      if (say != 0) islem($urandom_range(0, 3), 1'b0, rand_line(), g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
